// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory responder.
package dmem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 12;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_RD,
    DUMP_OUT
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Bundle of core-side, host-load and host-dump signals of the responder.
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // core side
  logic [ADDR_W-1:0] ar_in;
  logic [DATA_W-1:0] wdata_in;
  logic              dm_en;
  logic              end_process;
  logic [DATA_W-1:0] dm_out;
  logic              start_process;

  // host load stream
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;

  // host dump stream
  logic [ADDR_W-1:0] dump_base;
  logic [ADDR_W-1:0] dump_len;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              dump_ready;
  logic              done;

  // responder end
  modport slave (
    input  ar_in, wdata_in, dm_en, end_process,
    input  load_valid, load_data, load_last,
    input  dump_base, dump_len, dump_ready,
    output dm_out, start_process, load_ready,
    output dump_valid, dump_data, dump_last, done
  );

  // core / host end
  modport master (
    output ar_in, wdata_in, dm_en, end_process,
    output load_valid, load_data, load_last,
    output dump_base, dump_len, dump_ready,
    input  dm_out, start_process, load_ready,
    input  dump_valid, dump_data, dump_last, done
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port read-first synchronous RAM; read data register has no reset.
module dmem_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 12,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first access: rdata returns the word stored before this edge's write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: host load, core run window, then windowed result dump.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  dmem_state_t state_reg, state_next;

  logic [IDX_W-1:0]  ptr_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] len_reg;
  logic              load_ready_reg;
  logic              done_reg;
  logic              rd_core_reg;   // RAM output currently holds a core read
  logic              oob_reg;       // that core read was out of range
  logic [DATA_W-1:0] dm_hold_reg;   // dm_out value kept while RAM serves others

  logic              accept;
  logic              finish;
  logic              core_in_range;
  logic              is_last;
  logic              dump_valid;
  logic [ADDR_W:0]   dump_sum;
  logic [IDX_W-1:0]  dump_addr;
  logic [DATA_W-1:0] dm_out_val;

  logic              ram_en;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign core_in_range = ({1'b0, bus.ar_in} < DEPTH_X);
  assign dump_valid    = (state_reg == DUMP_OUT);
  assign is_last       = (idx_reg == (len_reg - ONE_A));
  assign dump_sum      = {1'b0, base_reg} + {1'b0, idx_reg};
  assign dump_addr     = IDX_W'(dump_sum % DEPTH_X);

  // Core read data comes straight from the RAM register while it holds a
  // core read; otherwise the last value seen by the core is replayed.
  assign dm_out_val = rd_core_reg ? (oob_reg ? '0 : ram_rdata) : dm_hold_reg;

  dmem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register; reset aborts any run or dump immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and RAM port steering between load pointer, core and dump.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = ptr_reg;
    ram_wdata  = bus.load_data;
    case (state_reg)
      IDLE, LOAD: begin
        if (bus.load_valid && load_ready_reg) begin
          accept     = 1'b1;
          ram_en     = 1'b1;
          ram_we     = 1'b1;
          state_next = bus.load_last ? RUN : LOAD;
        end
      end
      RUN: begin
        ram_en    = 1'b1;
        ram_we    = bus.dm_en && core_in_range;
        ram_addr  = bus.ar_in[IDX_W-1:0];
        ram_wdata = bus.wdata_in;
        if (bus.end_process) begin
          if (bus.dump_len == '0) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            state_next = DUMP_RD;
          end
        end
      end
      DUMP_RD: begin
        ram_en     = 1'b1;
        ram_addr   = dump_addr;
        state_next = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (bus.dump_ready) begin
          if (is_last) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            state_next = DUMP_RD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointers, dump window, registered handshake outputs and read-data tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg        <= '0;
      idx_reg        <= '0;
      base_reg       <= '0;
      len_reg        <= '0;
      load_ready_reg <= 1'b0;
      done_reg       <= 1'b0;
      rd_core_reg    <= 1'b0;
      oob_reg        <= 1'b0;
      dm_hold_reg    <= '0;
    end else begin
      load_ready_reg <= (state_next == IDLE) || (state_next == LOAD);
      done_reg       <= finish;
      rd_core_reg    <= (state_reg == RUN);
      oob_reg        <= !core_in_range;
      dm_hold_reg    <= dm_out_val;

      if (accept) begin
        ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
      end else if (state_next == IDLE && state_reg != IDLE) begin
        ptr_reg <= '0;
      end

      if (state_reg == RUN && bus.end_process) begin
        base_reg <= bus.dump_base;
        len_reg  <= bus.dump_len;
        idx_reg  <= '0;
      end else if (dump_valid && bus.dump_ready && !is_last) begin
        idx_reg <= idx_reg + ONE_A;
      end
    end
  end

  assign bus.dm_out        = dm_out_val;
  assign bus.start_process = (state_reg == RUN);
  assign bus.load_ready    = load_ready_reg;
  assign bus.dump_valid    = dump_valid;
  assign bus.dump_data     = dump_valid ? ram_rdata : '0;
  assign bus.dump_last     = dump_valid && is_last;
  assign bus.done          = done_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: load, core access, dump, abort by reset.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_responder_if #(.ADDR_W(12), .DATA_W(12)) bus_if ();

  dmem_responder #(.ADDR_W(12), .DATA_W(12), .DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One load beat offered at a falling edge, accepted at the next rising edge.
  task automatic load_beat(input logic [11:0] d, input logic l);
    bus_if.load_valid = 1'b1;
    bus_if.load_data  = d;
    bus_if.load_last  = l;
    @(negedge clk);
    bus_if.load_valid = 1'b0;
    bus_if.load_last  = 1'b0;
  endtask

  // One core cycle; dm_out for this address is visible on return.
  task automatic core(input logic [11:0] a, input logic en, input logic [11:0] wd);
    bus_if.ar_in    = a;
    bus_if.dm_en    = en;
    bus_if.wdata_in = wd;
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    check({tag, " dm_out"},        32'(bus_if.dm_out), 32'h0);
    check({tag, " start_process"}, 32'(bus_if.start_process), 32'h0);
    check({tag, " load_ready"},    32'(bus_if.load_ready), 32'h0);
    check({tag, " dump_valid"},    32'(bus_if.dump_valid), 32'h0);
    check({tag, " dump_data"},     32'(bus_if.dump_data), 32'h0);
    check({tag, " dump_last"},     32'(bus_if.dump_last), 32'h0);
    check({tag, " done"},          32'(bus_if.done), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.ar_in = '0;      bus_if.wdata_in = '0;   bus_if.dm_en = 1'b0;
    bus_if.end_process = 1'b0;
    bus_if.load_valid = 1'b0; bus_if.load_data = '0; bus_if.load_last = 1'b0;
    bus_if.dump_base = '0;  bus_if.dump_len = '0;   bus_if.dump_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("load_ready_before_edge", 32'(bus_if.load_ready), 32'h0);
    @(negedge clk);
    check("load_ready_after_edge", 32'(bus_if.load_ready), 32'h1);
    $display("step reset done");

    // load four words
    load_beat(12'h00A, 1'b0);
    load_beat(12'h00B, 1'b0);
    load_beat(12'h00C, 1'b0);
    check("start_before_last", 32'(bus_if.start_process), 32'h0);
    load_beat(12'h00D, 1'b1);
    check("start_after_last", 32'(bus_if.start_process), 32'h1);
    check("load_ready_in_run", 32'(bus_if.load_ready), 32'h0);
    $display("step load 4 words");

    // core reads of loaded words
    for (int a = 0; a < 4; a++) begin
      core(12'(a), 1'b0, 12'h000);
      check($sformatf("rd_mem%0d", a), 32'(bus_if.dm_out), 32'h00A + 32'(a));
    end
    $display("step core reads");

    // write, read-first, then new data
    core(12'h005, 1'b1, 12'h055);
    core(12'h005, 1'b1, 12'h123);
    check("rd_first_old", 32'(bus_if.dm_out), 32'h055);
    core(12'h005, 1'b0, 12'h000);
    check("rd_after_write", 32'(bus_if.dm_out), 32'h123);
    $display("step core write read-first");

    // window contents and out-of-range accesses
    core(12'h3FE, 1'b1, 12'h111);
    core(12'h3FF, 1'b1, 12'h222);
    core(12'h7FF, 1'b1, 12'h3AB);
    check("oob_7ff_read", 32'(bus_if.dm_out), 32'h0);
    core(12'h400, 1'b1, 12'h3CD);
    check("oob_400_read", 32'(bus_if.dm_out), 32'h0);
    core(12'h3FF, 1'b0, 12'h000);
    check("no_alias_3ff", 32'(bus_if.dm_out), 32'h222);
    core(12'h000, 1'b0, 12'h000);
    check("no_alias_000", 32'(bus_if.dm_out), 32'h00A);
    $display("step out-of-range writes dropped");

    // dump base 0x3FE len 3 with wrap and back-pressure
    bus_if.ar_in = 12'h002;
    bus_if.end_process = 1'b1;
    bus_if.dump_base = 12'h3FE;
    bus_if.dump_len = 12'd3;
    @(negedge clk);
    check("end_start_low", 32'(bus_if.start_process), 32'h0);
    check("end_dm_out", 32'(bus_if.dm_out), 32'h00C);
    check("dump_rd_valid", 32'(bus_if.dump_valid), 32'h0);
    bus_if.end_process = 1'b0;
    bus_if.dump_base = 12'h000;
    bus_if.dump_len = 12'd0;
    bus_if.dm_en = 1'b1;
    bus_if.wdata_in = 12'h0FF;
    @(negedge clk);
    check("beat0_valid", 32'(bus_if.dump_valid), 32'h1);
    check("beat0_data", 32'(bus_if.dump_data), 32'h111);
    check("beat0_last", 32'(bus_if.dump_last), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), 32'(bus_if.dump_valid), 32'h1);
      check($sformatf("stall%0d_data", i), 32'(bus_if.dump_data), 32'h111);
    end
    bus_if.dump_ready = 1'b1;
    @(negedge clk);
    check("gap1_valid", 32'(bus_if.dump_valid), 32'h0);
    @(negedge clk);
    check("beat1_data", 32'(bus_if.dump_data), 32'h222);
    check("beat1_last", 32'(bus_if.dump_last), 32'h0);
    @(negedge clk);
    check("gap2_valid", 32'(bus_if.dump_valid), 32'h0);
    @(negedge clk);
    check("beat2_valid", 32'(bus_if.dump_valid), 32'h1);
    check("beat2_data", 32'(bus_if.dump_data), 32'h00A);
    check("beat2_last", 32'(bus_if.dump_last), 32'h1);
    check("beat2_done", 32'(bus_if.done), 32'h0);
    @(negedge clk);
    check("dump_done", 32'(bus_if.done), 32'h1);
    check("dump_idle_valid", 32'(bus_if.dump_valid), 32'h0);
    check("dump_idle_ready", 32'(bus_if.load_ready), 32'h1);
    bus_if.dump_ready = 1'b0;
    bus_if.end_process = 1'b1;
    @(negedge clk);
    check("done_one_cycle", 32'(bus_if.done), 32'h0);
    check("dm_out_held", 32'(bus_if.dm_out), 32'h00C);
    @(negedge clk);
    check("idle_end_ignored", 32'(bus_if.start_process), 32'h0);
    check("idle_end_no_dump", 32'(bus_if.dump_valid), 32'h0);
    bus_if.end_process = 1'b0;
    bus_if.dm_en = 1'b0;
    $display("step dump with wrap and stall");

    // second run, ptr restarts at 0, zero-length dump
    load_beat(12'h0E1, 1'b0);
    load_beat(12'h0E2, 1'b1);
    check("run2_start", 32'(bus_if.start_process), 32'h1);
    core(12'h000, 1'b0, 12'h000);
    check("run2_mem0", 32'(bus_if.dm_out), 32'h0E1);
    core(12'h002, 1'b0, 12'h000);
    check("run2_mem2_kept", 32'(bus_if.dm_out), 32'h00C);
    bus_if.end_process = 1'b1;
    bus_if.dump_base = 12'h3FE;
    bus_if.dump_len = 12'd0;
    @(negedge clk);
    bus_if.end_process = 1'b0;
    check("len0_done", 32'(bus_if.done), 32'h1);
    check("len0_start", 32'(bus_if.start_process), 32'h0);
    check("len0_valid", 32'(bus_if.dump_valid), 32'h0);
    check("len0_ready", 32'(bus_if.load_ready), 32'h1);
    @(negedge clk);
    check("len0_done_drop", 32'(bus_if.done), 32'h0);
    $display("step zero-length dump");

    // abort mid-dump by reset
    load_beat(12'h0E7, 1'b1);
    bus_if.end_process = 1'b1;
    bus_if.dump_base = 12'h000;
    bus_if.dump_len = 12'd2;
    @(negedge clk);
    bus_if.end_process = 1'b0;
    @(negedge clk);
    check("abort_pre_valid", 32'(bus_if.dump_valid), 32'h1);
    check("abort_pre_data", 32'(bus_if.dump_data), 32'h0E7);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("abort");
    @(negedge clk);
    check("abort_no_done", 32'(bus_if.done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_load_ready", 32'(bus_if.load_ready), 32'h1);
    load_beat(12'h0F0, 1'b1);
    check("run3_start", 32'(bus_if.start_process), 32'h1);
    core(12'h000, 1'b0, 12'h000);
    check("run3_mem0", 32'(bus_if.dm_out), 32'h0F0);
    core(12'h001, 1'b0, 12'h000);
    check("run3_mem1_kept", 32'(bus_if.dm_out), 32'h0E2);
    core(12'h005, 1'b0, 12'h000);
    check("run3_mem5_kept", 32'(bus_if.dm_out), 32'h123);
    bus_if.end_process = 1'b1;
    bus_if.dump_len = 12'd0;
    @(negedge clk);
    bus_if.end_process = 1'b0;
    check("run3_done", 32'(bus_if.done), 32'h1);
    $display("step reset abort and reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
